// File: rtl/clint_arbiter.sv
// clint_arbiter: buffers one register-access request per core and serializes
// them onto the single CLINT slave port in round-robin order. The read data
// and a one-cycle ready pulse go back to the requesting core only.
`ifndef CORE_NUMS
`define CORE_NUMS 4
`endif

module clint_arbiter #(
    parameter int XLEN      = 32,
    parameter int CORE_NUMS = `CORE_NUMS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            core_strobe_i [0:CORE_NUMS-1],
    input  logic            core_we_i     [0:CORE_NUMS-1],
    input  logic [XLEN-1:0] core_addr_i   [0:CORE_NUMS-1],
    input  logic [XLEN-1:0] core_data_i   [0:CORE_NUMS-1],
    output logic [XLEN-1:0] core_data_o   [0:CORE_NUMS-1],
    output logic            core_ready_o  [0:CORE_NUMS-1],
    output logic            clint_en_o,
    output logic            clint_we_o,
    output logic [XLEN-1:0] clint_addr_o,
    output logic [XLEN-1:0] clint_data_o,
    input  logic [XLEN-1:0] clint_data_i,
    input  logic            clint_ready_i
);

    localparam int CW = (CORE_NUMS > 1) ? $clog2(CORE_NUMS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   rr_ptr_q;
    logic [CW-1:0]   gnt_q;

    // Pending request slots, one per core
    logic            slot_vld_q  [CORE_NUMS];
    logic            slot_we_q   [CORE_NUMS];
    logic [XLEN-1:0] slot_addr_q [CORE_NUMS];
    logic [XLEN-1:0] slot_data_q [CORE_NUMS];

    // Registered outputs
    logic            clint_en_q;
    logic            clint_we_q;
    logic [XLEN-1:0] clint_addr_q;
    logic [XLEN-1:0] clint_data_q;
    logic            core_ready_q [CORE_NUMS];
    logic [XLEN-1:0] core_data_q  [CORE_NUMS];

    logic            win_vld_d;
    logic [CW-1:0]   win_idx_d;
    logic            done_d;

    // Core index reached by stepping v places past slot 0, modulo CORE_NUMS
    function automatic logic [CW-1:0] wrap_idx(input int v);
        return CW'(v % CORE_NUMS);
    endfunction

    // Successor of a core index, wrapping from the last core back to 0
    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] idx);
        return (idx == CW'(CORE_NUMS - 1)) ? '0 : idx + CW'(1);
    endfunction

    // The outstanding transaction finishes when the CLINT answers in WAIT
    assign done_d = (state_q == WAIT) && clint_ready_i;

    // Round-robin pick: first valid slot scanning upward from rr_ptr
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        for (int i = 0; i < CORE_NUMS; i++) begin
            if (!win_vld_d && slot_vld_q[wrap_idx(int'(rr_ptr_q) + i)]) begin
                win_vld_d = 1'b1;
                win_idx_d = wrap_idx(int'(rr_ptr_q) + i);
            end
        end
    end

    // Slot capture on strobe into an empty slot; release when its access completes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < CORE_NUMS; n++) begin
                slot_vld_q[n]  <= 1'b0;
                slot_we_q[n]   <= 1'b0;
                slot_addr_q[n] <= '0;
                slot_data_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < CORE_NUMS; n++) begin
                if (done_d && (gnt_q == CW'(n))) begin
                    slot_vld_q[n] <= 1'b0;
                end else if (core_strobe_i[n] && !slot_vld_q[n]) begin
                    // A strobe into an occupied slot (queued or in flight) is dropped
                    slot_vld_q[n]  <= 1'b1;
                    slot_we_q[n]   <= core_we_i[n];
                    slot_addr_q[n] <= core_addr_i[n];
                    slot_data_q[n] <= core_data_i[n];
                end
            end
        end
    end

    // Grant / issue / wait sequencing with all CLINT and core outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            clint_en_q   <= 1'b0;
            clint_we_q   <= 1'b0;
            clint_addr_q <= '0;
            clint_data_q <= '0;
            for (int n = 0; n < CORE_NUMS; n++) begin
                core_ready_q[n] <= 1'b0;
                core_data_q[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < CORE_NUMS; n++) begin
                core_ready_q[n] <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        clint_en_q   <= 1'b1;
                        clint_we_q   <= slot_we_q[win_idx_d];
                        clint_addr_q <= slot_addr_q[win_idx_d];
                        clint_data_q <= slot_data_q[win_idx_d];
                        gnt_q        <= win_idx_d;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Enable is a single-cycle strobe; a ready seen here is ignored
                    clint_en_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (clint_ready_i) begin
                        core_data_q[gnt_q]  <= clint_data_i;
                        core_ready_q[gnt_q] <= 1'b1;
                        rr_ptr_q            <= next_idx(gnt_q);
                        state_q             <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign clint_en_o   = clint_en_q;
    assign clint_we_o   = clint_we_q;
    assign clint_addr_o = clint_addr_q;
    assign clint_data_o = clint_data_q;
    assign core_ready_o = core_ready_q;
    assign core_data_o  = core_data_q;

endmodule
